serial_to_parallel: RTL

Receive-side deserializer for the Hamming link: collects an LSB-first serial bit stream, one bit per `shift` strobe, into a WIDTH-bit word and presents it on a held parallel output with a valid/acknowledge handshake. It sits between the serial channel and the Hamming decoder and is the receiving end of the transmit-side shift-right serializer, whose bit 0 goes out first. Framing is explicit: `start` opens a frame, and exactly WIDTH strobes complete it.

---
 rtl/hamming_pkg.sv | 14 +
 rtl/stp_bit_counter.sv | 32 +++
 rtl/serial_to_parallel.sv | 107 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming link: codeword/data widths and the
// deserializer state encoding.
package hamming_pkg;

  localparam int CODEWORD_W = 7;
  localparam int DATA_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } stp_state_e;

endpackage

// File: rtl/stp_bit_counter.sv
// Clearable up-counter with a terminal flag at WIDTH-1; frame bit counter for
// both the receive deserializer and the transmit frame controller.
module stp_bit_counter
  import hamming_pkg::*;
#(
  parameter int WIDTH = CODEWORD_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_terminal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] r_count;

  // Clear has priority so a frame restart never counts the aborted strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer: start opens a frame, WIDTH shift strobes fill it,
// and the word is held on data_out under a valid/acknowledge handshake.
module serial_to_parallel
  import hamming_pkg::*;
#(
  parameter int WIDTH = CODEWORD_W
) (
  input  logic             clk,
  input  logic             stp_reset,
  input  logic             start,
  input  logic             shift,
  input  logic             serial_in,
  input  logic             read_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output stp_state_e       dbg_state
);

  // Handshake: data_valid stays high from word completion until an edge sees
  // read_ack; the consumer may read data_out any time data_valid is high.

  stp_state_e       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_busy;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sr_next;
  logic             w_terminal;
  logic             w_cnt_clear;
  logic             w_cnt_inc;

  assign w_sr_next   = {serial_in, r_sr[WIDTH-1:1]};
  assign w_cnt_inc   = (r_state == ST_SHIFT) && shift;
  assign w_cnt_clear = start || (w_cnt_inc && w_terminal);

  stp_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk        (clk),
    .rst        (stp_reset),
    .i_clear    (w_cnt_clear),
    .i_inc      (w_cnt_inc),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or posedge stp_reset) begin
    if (stp_reset) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_sr    <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // start beats a coincident strobe: the partial frame is dropped.
          if (start) begin
            r_sr <= '0;
          end else if (shift) begin
            r_sr <= w_sr_next;
            if (w_terminal) begin
              r_data_out   <= w_sr_next;
              r_data_valid <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (read_ack) begin
            r_data_valid <= 1'b0;
            if (start) begin
              r_state <= ST_SHIFT;
              r_sr    <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (start) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign dbg_state  = r_state;

endmodule
